acc_feeder: RTL and testbench

Upstream control stage for the accumulator core. On a start command it clears the core with a one-cycle `run` pulse. It then reads `N` operands from a single-port, 1-cycle-latency memory and streams them to the core as `number`/`valid`. After the core's 2-cycle latency it captures the final sum and reports `done`. It sits between the host/register interface and the accumulator core, and it owns the memory read port.

---
 rtl/acc_feeder.sv | 133 +++++++++++++
 tb/tb_acc_feeder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_feeder.sv
// Accumulator feeder: clears the core, streams N memory operands, captures the sum.
// Optional ACC_FEEDER_ERR_EN adds a sticky err_o flag for rejected start requests.
module acc_feeder #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int DWIDTH        = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic [ADDR_WIDTH:0]      num_cnt_i,
  output logic                     mem_ce_o,
  output logic [ADDR_WIDTH-1:0]    mem_addr_o,
  input  logic [IN_DATA_WIDTH-1:0] mem_q_i,
  output logic                     run_o,
  output logic                     valid_o,
  output logic [IN_DATA_WIDTH-1:0] number_o,
  input  logic [DWIDTH-1:0]        core_result_i,
  output logic                     idle_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [DWIDTH-1:0]        result_o
`ifdef ACC_FEEDER_ERR_EN
  ,
  output logic                     err_o
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_WIDTH:0] MAX_N = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_tgt_q, cnt_tgt_d;
  logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [DWIDTH-1:0]     result_q, result_d;
  logic                  legal;
  logic                  is_idle;
  logic                  is_fetch;

  assign legal    = (num_cnt_i != '0) && (num_cnt_i <= MAX_N);
  assign is_idle  = (state_q == S_IDLE);
  assign is_fetch = (state_q == S_FETCH);

  always_comb begin
    state_d   = state_q;
    cnt_tgt_d = cnt_tgt_q;
    rd_cnt_d  = rd_cnt_q;
    result_d  = result_q;
    done_d    = 1'b0;
    valid_d   = is_fetch;
    case (state_q)
      S_IDLE: begin
        if (start_i && legal) begin
          cnt_tgt_d = num_cnt_i;
          rd_cnt_d  = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN:   state_d = S_FETCH;
      S_FETCH: begin
        rd_cnt_d = rd_cnt_q + ONE;
        if (rd_cnt_q == cnt_tgt_q - ONE)
          state_d = S_WAIT;
      end
      S_WAIT:  state_d = S_DONE;
      S_DONE: begin
        result_d = core_result_i;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_tgt_q <= '0;
      rd_cnt_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_tgt_q <= cnt_tgt_d;
      rd_cnt_q  <= rd_cnt_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

`ifdef ACC_FEEDER_ERR_EN
  logic err_q, err_d;
  logic accept;

  assign accept = is_idle && start_i && legal;

  always_comb begin
    err_d = err_q;
    if (accept)
      err_d = 1'b0;
    else if (start_i)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err_o = err_q;
`endif

  assign run_o      = (state_q == S_RUN);
  assign mem_ce_o   = is_fetch;
  assign mem_addr_o = is_fetch ? rd_cnt_q[ADDR_WIDTH-1:0] : '0;
  assign valid_o    = valid_q;
  assign number_o   = mem_q_i;
  assign idle_o     = is_idle;
  assign busy_o     = !is_idle;
  assign done_o     = done_q;
  assign result_o   = result_q;

endmodule

// File: tb/tb_acc_feeder.sv
// Bench for acc_feeder: memory and accumulator-core models plus a
// start-relative timing table for every output.
module tb_acc_feeder;

  localparam int IW = 8;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_i;
  logic [AW:0]   num_cnt_i;
  logic          mem_ce_o;
  logic [AW-1:0] mem_addr_o;
  logic [IW-1:0] mem_q_i;
  logic          run_o;
  logic          valid_o;
  logic [IW-1:0] number_o;
  logic [DW-1:0] core_result_i;
  logic          idle_o;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] result_o;
`ifdef ACC_FEEDER_ERR_EN
  logic          err_o;
`endif

  acc_feeder #(
    .IN_DATA_WIDTH(IW),
    .ADDR_WIDTH(AW),
    .DWIDTH(DW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start_i(start_i),
    .num_cnt_i(num_cnt_i),
    .mem_ce_o(mem_ce_o),
    .mem_addr_o(mem_addr_o),
    .mem_q_i(mem_q_i),
    .run_o(run_o),
    .valid_o(valid_o),
    .number_o(number_o),
    .core_result_i(core_result_i),
    .idle_o(idle_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .result_o(result_o)
`ifdef ACC_FEEDER_ERR_EN
    ,
    .err_o(err_o)
`endif
  );

  always #5 clk = ~clk;

  logic [IW-1:0] mem [256];
  logic [DW-1:0] acc;

  always @(posedge clk)
    if (mem_ce_o) mem_q_i <= mem[mem_addr_o];

  always @(posedge clk)
    if (run_o)        acc <= '0;
    else if (valid_o) acc <= acc + DW'(number_o);

  assign core_result_i = acc;

  int n_cmp = 0;
  int n_bad = 0;
  int prev_res = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".ce"}, 32'(mem_ce_o), 0);
    check({tag, ".addr"}, 32'(mem_addr_o), 0);
    check({tag, ".run"}, 32'(run_o), 0);
    check({tag, ".valid"}, 32'(valid_o), 0);
    check({tag, ".done"}, 32'(done_o), 0);
    check({tag, ".result"}, 32'(result_o), 0);
    check({tag, ".idle"}, 32'(idle_o), 1);
    check({tag, ".busy"}, 32'(busy_o), 0);
`ifdef ACC_FEEDER_ERR_EN
    check({tag, ".err"}, 32'(err_o), 0);
`endif
  endtask

  // Start at the current cycle S; t counts cycles after S.
  task automatic run_n(input int n, input bit poke);
    int exp_sum;
    bit ce_e, val_e, last;
    exp_sum = 0;
    for (int i = 0; i < n; i++) exp_sum += int'(mem[i]);
    exp_sum = exp_sum % 65536;
    num_cnt_i = (AW+1)'(n);
    start_i = 1'b1;
    for (int t = 1; t <= n + 4; t++) begin
      tick();
      if (t == 1) start_i = 1'b0;
      ce_e  = (t >= 2) && (t <= n + 1);
      val_e = (t >= 3) && (t <= n + 2);
      last  = (t == n + 4);
      check("run", 32'(run_o), 32'(t == 1));
      check("ce", 32'(mem_ce_o), 32'(ce_e));
      check("addr", 32'(mem_addr_o), ce_e ? 32'((t - 2) % 256) : 0);
      check("valid", 32'(valid_o), 32'(val_e));
      if (val_e) check("number", 32'(number_o), 32'(mem[t - 3]));
      check("idle", 32'(idle_o), 32'(last));
      check("busy", 32'(busy_o), 32'(!last));
      check("done", 32'(done_o), 32'(last));
      check("result", 32'(result_o), last ? 32'(exp_sum) : 32'(prev_res));
`ifdef ACC_FEEDER_ERR_EN
      if (t == 1) check("err_clr", 32'(err_o), 0);
      if (last)   check("err_end", 32'(err_o), 32'(poke));
`endif
      if (poke && t == 3) begin
        start_i = 1'b1;
        num_cnt_i = 9;
      end
      if (poke && t == 4) start_i = 1'b0;
    end
    prev_res = exp_sum;
  endtask

  task automatic try_illegal(input int v);
    num_cnt_i = (AW+1)'(v);
    start_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ill.idle", 32'(idle_o), 1);
      check("ill.ce", 32'(mem_ce_o), 0);
      check("ill.run", 32'(run_o), 0);
      check("ill.done", 32'(done_o), 0);
`ifdef ACC_FEEDER_ERR_EN
      check("ill.err", 32'(err_o), 1);
`endif
    end
    start_i = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start_i = 1'b0;
    num_cnt_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    tick();
    tick();
    check_reset_vals("rst");
    reset_n = 1'b1;
    tick();
    check_reset_vals("post_rst");

    mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
    run_n(4, 1'b0);
    tick();

    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    run_n(256, 1'b0);
    tick();

    try_illegal(0);
    try_illegal(257);
    tick();

    mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
    run_n(4, 1'b1);
    mem[0] = 5; mem[1] = 6;
    run_n(2, 1'b0);
    tick();

    num_cnt_i = 5;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("mid.ce_before", 32'(mem_ce_o), 1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    tick();
    reset_n = 1'b1;
    tick();
    prev_res = 0;
    check_reset_vals("mid_after");
    mem[0] = 7; mem[1] = 7; mem[2] = 7;
    run_n(3, 1'b0);

    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
      run_n(n, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check("gap.idle", 32'(idle_o), 1);
        check("gap.done", 32'(done_o), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
